// File: rtl/sprite_motion_ctrl_pkg.sv
// sprite_motion_ctrl_pkg: shared key indices, direction/state enums and key decoding for sprite motion
package sprite_motion_ctrl_pkg;
  localparam int KEY_UP = 0;
  localparam int KEY_LEFT = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_RIGHT = 3;
  typedef enum logic [1:0] {NONE, NEG, POS} dir_t;
  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} axis_state_t;
  // Exactly one key of a pair selects a direction; none or both cancel out.
  function automatic dir_t key_dir(input logic neg, input logic pos);
    return (neg ^ pos) ? (neg ? NEG : POS) : NONE;
  endfunction
endpackage

// File: rtl/motion_axis.sv
// motion_axis: one accelerating, bound-clamped position axis stepped on motion ticks
import sprite_motion_ctrl_pkg::*;
module motion_axis #(
  parameter int POS_W = 10,
  parameter int MIN = 0,
  parameter int MAX = 639,
  parameter int INIT = 200,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             key_neg,
  input  logic             key_pos,
  output logic [POS_W-1:0] pos,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             active,
  output logic             at_edge
);
  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int AW = $clog2(ACCEL_TICKS + 1);
  localparam int EW = POS_W + 2;
  localparam logic [SW-1:0] SMAX = SW'(MAX_SPEED);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [AW-1:0] ALAST = AW'(ACCEL_TICKS - 1);
  // The entry/reversal tick already counts as one tick spent at speed 1.
  localparam logic [AW-1:0] AENTRY = AW'(ACCEL_TICKS > 1 ? 1 : 0);
  localparam logic [EW-1:0] LO = EW'(MIN);
  localparam logic [EW-1:0] HI = EW'(MAX);
  localparam axis_state_t ENTRY = (MAX_SPEED == 1) ? CRUISE : ACCEL;
  if (INIT < MIN || INIT > MAX || MIN > MAX || MAX_SPEED < 1 || ACCEL_TICKS < 1) begin : g_param_check
    $error("motion_axis: INIT outside [MIN,MAX] or bad speed parameters");
  end
  axis_state_t state, state_n;
  dir_t dir, cur_dir;
  logic [SW-1:0] speed, speed_n, step;
  logic [AW-1:0] acc, acc_n;
  logic [EW-1:0] sum;
  logic [POS_W-1:0] pos_n;
  // Next speed/state from the key pair, then a two-bit-wider signed-safe step clamped to the bounds.
  always_comb begin
    dir = key_dir(key_neg, key_pos);
    state_n = state;
    speed_n = speed;
    acc_n = acc;
    step = '0;
    if (dir == NONE) begin
      state_n = IDLE;
      speed_n = '0;
      acc_n = '0;
    end else if (state == IDLE || dir != cur_dir) begin
      step = SONE;
      speed_n = SONE;
      acc_n = AENTRY;
      state_n = ENTRY;
    end else if (state == CRUISE) begin
      step = SMAX;
    end else begin
      step = speed;
      acc_n = (acc == ALAST) ? '0 : acc + 1'b1;
      speed_n = (acc == ALAST) ? speed + 1'b1 : speed;
      state_n = (acc == ALAST && speed + 1'b1 == SMAX) ? CRUISE : ACCEL;
    end
    sum = (dir == POS) ? {2'b00, pos} + EW'(step) : {2'b00, pos} - EW'(step);
    pos_n = (sum[EW-1] || sum < LO) ? POS_W'(MIN) : (sum > HI) ? POS_W'(MAX) : sum[POS_W-1:0];
  end
  // Axis state advances only on ticks; pulses flag an actual position change for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= POS_W'(INIT);
      state <= IDLE;
      cur_dir <= NONE;
      speed <= '0;
      acc <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      inc_pulse <= tick && pos_n > pos;
      dec_pulse <= tick && pos_n < pos;
      if (tick) begin
        pos <= pos_n;
        state <= state_n;
        cur_dir <= dir;
        speed <= speed_n;
        acc <= acc_n;
      end
    end
  end
  assign active = state != IDLE;
  assign at_edge = pos == POS_W'(MIN) || pos == POS_W'(MAX);
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: key-driven sprite X/Y motion with tick-rate stepping, acceleration and bounds
import sprite_motion_ctrl_pkg::*;
module sprite_motion_ctrl #(
  parameter int POS_W = 10,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int X_INIT = 200,
  parameter int Y_INIT = 200,
  parameter int TICK_DIV = 1666667,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       keys_pressed,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             shift_left,
  output logic             shift_right,
  output logic             moving,
  output logic [1:0]       at_edge
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  if (TICK_DIV < 2) begin : g_div_check
    $error("sprite_motion_ctrl: TICK_DIV must be at least 2");
  end
  logic [CW-1:0] cnt;
  logic tick, x_active, y_active, unused_key, unused_y_inc, unused_y_dec;
  assign tick = cnt == LAST;
  assign unused_key = keys_pressed[4];
  // Free-running motion tick divider; reset restarts the phase.
  always_ff @(posedge clk) begin
    cnt <= (rst || tick) ? '0 : cnt + 1'b1;
  end
  motion_axis #(
    .POS_W(POS_W), .MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT),
    .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
  ) u_x (
    .clk(clk), .rst(rst), .tick(tick),
    .key_neg(keys_pressed[KEY_LEFT]), .key_pos(keys_pressed[KEY_RIGHT]),
    .pos(hpos), .inc_pulse(shift_right), .dec_pulse(shift_left),
    .active(x_active), .at_edge(at_edge[0])
  );
  motion_axis #(
    .POS_W(POS_W), .MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT),
    .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
  ) u_y (
    .clk(clk), .rst(rst), .tick(tick),
    .key_neg(keys_pressed[KEY_UP]), .key_pos(keys_pressed[KEY_DOWN]),
    .pos(vpos), .inc_pulse(unused_y_inc), .dec_pulse(unused_y_dec),
    .active(y_active), .at_edge(at_edge[1])
  );
  assign moving = x_active | y_active;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: scoreboard-driven checks of sprite motion stepping, bounds and pulses
module tb_sprite_motion_ctrl;
  localparam logic [4:0] K_UP = 5'b00001;
  localparam logic [4:0] K_LEFT = 5'b00010;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] keys = '0;
  logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic sl_a, sr_a, mv_a, sl_b, sr_b, mv_b;
  logic [1:0] edge_a, edge_b;
  int checks = 0;
  int failures = 0;
  int sl_a_n = 0;
  int sr_a_n = 0;
  int sl_b_n = 0;
  logic [22:0] exp_q[$];
  sprite_motion_ctrl #(.TICK_DIV(4), .MAX_SPEED(3), .ACCEL_TICKS(2)) dut_a (
    .clk(clk), .rst(rst), .keys_pressed(keys), .hpos(hpos_a), .vpos(vpos_a),
    .shift_left(sl_a), .shift_right(sr_a), .moving(mv_a), .at_edge(edge_a)
  );
  sprite_motion_ctrl #(.X_INIT(1), .TICK_DIV(4), .MAX_SPEED(3), .ACCEL_TICKS(2)) dut_b (
    .clk(clk), .rst(rst), .keys_pressed(keys), .hpos(hpos_b), .vpos(vpos_b),
    .shift_left(sl_b), .shift_right(sr_b), .moving(mv_b), .at_edge(edge_b)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sl_a) sl_a_n++;
    if (sr_a) sr_a_n++;
    if (sl_b) sl_b_n++;
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic step(input logic [4:0] k, input bit use_b, input int eh, input int ev,
                      input logic esl, input logic esr, input logic emv, input string nm);
    logic [22:0] got, e;
    @(negedge clk);
    keys = k;
    exp_q.push_back({10'(eh), 10'(ev), esl, esr, emv});
    repeat (4) @(posedge clk);
    #1;
    got = use_b ? {hpos_b, vpos_b, sl_b, sr_b, mv_b} : {hpos_a, vpos_a, sl_a, sr_a, mv_a};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got h=%0d v=%0d sl=%b sr=%b mv=%b, want h=%0d v=%0d sl=%b sr=%b mv=%b",
               nm, got[22:13], got[12:3], got[2], got[1], got[0], e[22:13], e[12:3], e[2], e[1], e[0]);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({hpos_a, vpos_a, sl_a, sr_a, mv_a, edge_a} !== {10'd200, 10'd200, 3'b000, 2'b00}) begin
      failures++;
      $display("FAIL reset_a: got h=%0d v=%0d sl=%b sr=%b mv=%b edge=%b, want 200 200 0 0 0 00",
               hpos_a, vpos_a, sl_a, sr_a, mv_a, edge_a);
    end
    checks++;
    if ({hpos_b, edge_b} !== {10'd1, 2'b00}) begin
      failures++;
      $display("FAIL reset_b: got h=%0d edge=%b, want h=1 edge=00", hpos_b, edge_b);
    end
  endtask
  task automatic test_hold_right();
    int exp_h[6] = '{201, 202, 204, 206, 209, 212};
    int s0;
    do_reset();
    s0 = sr_a_n;
    for (int i = 0; i < 6; i++) step(K_RIGHT, 1'b0, exp_h[i], 200, 1'b0, 1'b1, 1'b1, "hold_right");
    step('0, 1'b0, 212, 200, 1'b0, 1'b0, 1'b0, "right_release");
    checks++;
    if (sr_a_n - s0 !== 6) begin
      failures++;
      $display("FAIL right_pulse_count: got %0d, want 6", sr_a_n - s0);
    end
  endtask
  task automatic test_both_keys();
    int s0, s1;
    do_reset();
    s0 = sr_a_n;
    s1 = sl_a_n;
    for (int i = 0; i < 3; i++) step(K_LEFT | K_RIGHT, 1'b0, 200, 200, 1'b0, 1'b0, 1'b0, "left_right");
    checks++;
    if ((sr_a_n - s0) + (sl_a_n - s1) !== 0) begin
      failures++;
      $display("FAIL both_pulse_count: got %0d, want 0", (sr_a_n - s0) + (sl_a_n - s1));
    end
  endtask
  task automatic test_left_edge();
    int s0;
    do_reset();
    s0 = sl_b_n;
    step(K_LEFT, 1'b1, 0, 200, 1'b1, 1'b0, 1'b1, "edge_first");
    for (int i = 0; i < 4; i++) step(K_LEFT, 1'b1, 0, 200, 1'b0, 1'b0, 1'b1, "edge_clamped");
    checks++;
    if (edge_b !== 2'b01) begin
      failures++;
      $display("FAIL edge_flag: got %b, want 01", edge_b);
    end
    checks++;
    if (sl_b_n - s0 !== 1) begin
      failures++;
      $display("FAIL edge_pulse_count: got %0d, want 1", sl_b_n - s0);
    end
  endtask
  task automatic test_reverse();
    int up_h[5] = '{201, 202, 204, 206, 209};
    int dn_h[5] = '{208, 207, 205, 203, 200};
    do_reset();
    for (int i = 0; i < 5; i++) step(K_RIGHT, 1'b0, up_h[i], 200, 1'b0, 1'b1, 1'b1, "rev_right");
    for (int i = 0; i < 5; i++) step(K_LEFT, 1'b0, dn_h[i], 200, 1'b1, 1'b0, 1'b1, "rev_left");
  endtask
  task automatic test_diag_rst();
    int dh[5] = '{201, 202, 204, 206, 209};
    int dv[5] = '{199, 198, 196, 194, 191};
    do_reset();
    for (int i = 0; i < 5; i++) step(K_UP | K_RIGHT, 1'b0, dh[i], dv[i], 1'b0, 1'b1, 1'b1, "diag");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({hpos_a, vpos_a, sr_a, mv_a} !== {10'd200, 10'd200, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_rst: got h=%0d v=%0d sr=%b mv=%b, want 200 200 0 0", hpos_a, vpos_a, sr_a, mv_a);
    end
  endtask
  initial begin
    test_reset();
    test_hold_right();
    test_both_keys();
    test_left_edge();
    test_reverse();
    test_diag_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
